// File: rtl/aes_rkey_store.sv
// AES round-key store: captures NKEYS round keys from the key expander and
// replays them forward (encrypt) or backward (decrypt) over a valid/ready port.
module aes_rkey_store #(
  parameter int NKEYS = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fill_start,
  input  logic         rk_in_valid,
  input  logic [127:0] rk_in,
  input  logic         replay_start,
  input  logic         replay_dir,
  input  logic         rk_out_ready,
  output logic         rk_out_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_out_idx,
  output logic         rk_out_last,
  output logic         keys_ready,
  output logic         busy,
  output logic         overflow_err
);

  localparam logic [3:0] LAST = 4'(NKEYS - 1);

  typedef enum logic [1:0] {IDLE, FILL, STORED, REPLAY} state_e;

  state_e       state_q;
  logic [127:0] mem_q [NKEYS];
  logic [3:0]   count_q, ptr_q;
  logic         dir_q;
  logic         vld_q, last_q, ready_q, ovf_q;
  logic [127:0] out_q;
  logic [3:0]   idx_q;

  logic         wr_en;
  logic [3:0]   wr_idx;
  logic [3:0]   ptr_d, start_ptr, end_ptr;

  // fill_start always targets slot 0, even while a previous fill is underway
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = count_q;
    if (!reset) begin
      if (fill_start) begin
        wr_en  = rk_in_valid;
        wr_idx = '0;
      end else if (state_q == FILL) begin
        wr_en  = rk_in_valid;
      end
    end
  end

  always_comb begin
    ptr_d     = dir_q ? (ptr_q - 4'd1) : (ptr_q + 4'd1);
    start_ptr = replay_dir ? LAST : 4'd0;
    end_ptr   = dir_q ? 4'd0 : LAST;
  end

  // Key array deliberately has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= rk_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      out_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (fill_start) begin
      state_q <= FILL;
      count_q <= '0;
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      if (rk_in_valid) begin
        if (LAST == 4'd0) begin
          state_q <= STORED;
          ready_q <= 1'b1;
        end else begin
          count_q <= 4'd1;
        end
      end
    end else begin
      case (state_q)
        IDLE: ;
        FILL: begin
          if (rk_in_valid) begin
            if (count_q == LAST) begin
              state_q <= STORED;
              ready_q <= 1'b1;
            end else begin
              count_q <= count_q + 4'd1;
            end
          end
        end
        STORED: begin
          if (rk_in_valid) ovf_q <= 1'b1;
          if (replay_start) begin
            state_q <= REPLAY;
            dir_q   <= replay_dir;
            ptr_q   <= start_ptr;
            out_q   <= mem_q[start_ptr];
            idx_q   <= start_ptr;
            last_q  <= (LAST == 4'd0);
            vld_q   <= 1'b1;
          end
        end
        REPLAY: begin
          if (rk_in_valid) ovf_q <= 1'b1;
          if (vld_q && rk_out_ready) begin
            if (last_q) begin
              state_q <= STORED;
              vld_q   <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              ptr_q  <= ptr_d;
              out_q  <= mem_q[ptr_d];
              idx_q  <= ptr_d;
              last_q <= (ptr_d == end_ptr);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rk_out_valid = vld_q;
  assign rk_out       = out_q;
  assign rk_out_idx   = idx_q;
  assign rk_out_last  = last_q;
  assign keys_ready   = ready_q;
  assign overflow_err = ovf_q;
  assign busy         = (state_q == FILL) || (state_q == REPLAY);

endmodule

// File: tb/tb_aes_rkey_store.sv
// Bench for aes_rkey_store: FIPS-197 round keys plus random fills/replays
// checked against an array/queue model of the stored keys.
module tb_aes_rkey_store;

  logic         clk = 1'b0;
  logic         reset, fill_start, rk_in_valid, replay_start, replay_dir, rk_out_ready;
  logic [127:0] rk_in;
  logic         rk_out_valid, rk_out_last, keys_ready, busy, overflow_err;
  logic [127:0] rk_out;
  logic [3:0]   rk_out_idx;

  aes_rkey_store #(.NKEYS(11)) dut (
    .clk(clk), .reset(reset), .fill_start(fill_start), .rk_in_valid(rk_in_valid),
    .rk_in(rk_in), .replay_start(replay_start), .replay_dir(replay_dir),
    .rk_out_ready(rk_out_ready), .rk_out_valid(rk_out_valid), .rk_out(rk_out),
    .rk_out_idx(rk_out_idx), .rk_out_last(rk_out_last), .keys_ready(keys_ready),
    .busy(busy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  logic [127:0] mdl_keys [11];
  bit           mdl_ovf;
  logic [127:0] fill_src [11];

  logic [127:0] obs_key[$];
  int           obs_idx[$];
  bit           obs_last[$];
  int           hold_bad, rp_cycles;
  bit           rp_first_vld, rp_post_vld, rp_timeout;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    reset = 0; fill_start = 0; rk_in_valid = 0; rk_in = '0;
    replay_start = 0; replay_dir = 0; rk_out_ready = 0;
  endtask

  task automatic rand_src();
    for (int i = 0; i < 11; i++) fill_src[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic commit_model();
    for (int i = 0; i < 11; i++) mdl_keys[i] = fill_src[i];
  endtask

  // Stimulus only: drives an 11-key fill, optionally with idle gaps.
  task automatic do_fill(input bit gaps);
    int g;
    for (int i = 0; i < 11; i++) begin
      if (gaps && i > 0) begin
        g = $urandom_range(0, 2);
        fill_start = 0; rk_in_valid = 0;
        repeat (g) step();
      end
      fill_start = (i == 0); rk_in_valid = 1; rk_in = fill_src[i];
      step();
    end
    fill_start = 0; rk_in_valid = 0;
  endtask

  // Acts as the consumer; records transfers and hold violations for the caller.
  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic collect_replay(input bit dir, input int mode);
    bit r, xfer;
    logic [127:0] pk; logic [3:0] pi; logic pl;
    obs_key.delete(); obs_idx.delete(); obs_last.delete();
    hold_bad = 0; rp_cycles = 0; rp_timeout = 1;
    replay_dir = dir; replay_start = 1; rk_out_ready = 0;
    step();
    replay_start = 0; replay_dir = 1'($urandom);
    rp_first_vld = rk_out_valid;
    for (int k = 0; k < 200; k++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (k % 4 == 0) || (k % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rk_out_ready = r;
      pk = rk_out; pi = rk_out_idx; pl = rk_out_last;
      xfer = rk_out_valid && r;
      if (xfer) begin
        obs_key.push_back(rk_out); obs_idx.push_back(int'(rk_out_idx)); obs_last.push_back(rk_out_last);
      end
      step();
      rp_cycles++;
      if (xfer && pl) begin rp_timeout = 0; break; end
      if (!xfer && (rk_out !== pk || rk_out_idx !== pi || rk_out_last !== pl)) hold_bad++;
    end
    rk_out_ready = 0;
    rp_post_vld = rk_out_valid;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1;
    step(); step();
    reset = 0;
    n_cmp++; if (rk_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", rk_out_valid); end
    n_cmp++; if (rk_out !== 128'h0) begin n_err++; $display("FAIL reset_rk_out got %h want 0", rk_out); end
    n_cmp++; if (rk_out_idx !== 4'd0 || rk_out_last !== 1'b0) begin n_err++; $display("FAIL reset_idx_last got %0d/%b want 0/0", rk_out_idx, rk_out_last); end
    n_cmp++; if (keys_ready !== 1'b0 || busy !== 1'b0 || overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_flags got kr=%b busy=%b ovf=%b want 0/0/0", keys_ready, busy, overflow_err); end
    // A key with no fill in progress is ignored silently
    rk_in_valid = 1; rk_in = 128'hdead; step(); rk_in_valid = 0;
    n_cmp++; if (overflow_err !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_key_ignored got ovf=%b busy=%b want 0/0", overflow_err, busy); end
    mdl_ovf = 0;
  endtask

  task automatic test_fips_fill();
    fill_src[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    fill_src[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    fill_src[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    fill_src[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    fill_src[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    fill_src[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    fill_src[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    fill_src[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    fill_src[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    fill_src[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    fill_src[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    // replay_start before any fill must be ignored
    replay_start = 1; step(); replay_start = 0;
    n_cmp++; if (rk_out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_replay_ignored got vld=%b busy=%b want 0/0", rk_out_valid, busy); end
    for (int i = 0; i < 11; i++) begin
      fill_start = (i == 0); rk_in_valid = 1; rk_in = fill_src[i];
      step();
      if (i == 9) begin
        n_cmp++; if (keys_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL fill_partial got kr=%b busy=%b want 0/1", keys_ready, busy); end
      end
    end
    fill_start = 0; rk_in_valid = 0;
    n_cmp++; if (keys_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL fips_fill_done got kr=%b busy=%b want 1/0", keys_ready, busy); end
    commit_model();
  endtask

  task automatic test_replay_decrypt();
    collect_replay(1'b1, 0);
    n_cmp++; if (rp_timeout || obs_key.size() != 11) begin n_err++; $display("FAIL dec_count got %0d keys (timeout=%b) want 11", obs_key.size(), rp_timeout); end
    n_cmp++; if (rp_first_vld !== 1'b1 || rp_cycles != 11) begin n_err++; $display("FAIL dec_timing got first_vld=%b cycles=%0d want 1/11", rp_first_vld, rp_cycles); end
    if (obs_key.size() == 11) begin
      n_cmp++; if (obs_key[0] !== 128'h13111d7fe3944a17f307a78b4d2b30c5 || obs_idx[0] != 10) begin n_err++; $display("FAIL dec_first got %h idx %0d want 13111d7fe3944a17f307a78b4d2b30c5 idx 10", obs_key[0], obs_idx[0]); end
      n_cmp++; if (obs_key[10] !== 128'h000102030405060708090a0b0c0d0e0f || obs_idx[10] != 0 || obs_last[10] != 1'b1) begin n_err++; $display("FAIL dec_last got %h idx %0d last %b want 000102030405060708090a0b0c0d0e0f idx 0 last 1", obs_key[10], obs_idx[10], obs_last[10]); end
      for (int i = 0; i < 11; i++) begin
        n_cmp++;
        if (obs_idx[i] != 10 - i || obs_key[i] !== mdl_keys[10 - i] || obs_last[i] != (i == 10)) begin
          n_err++; $display("FAIL dec_seq[%0d] got idx %0d key %h last %b want idx %0d key %h last %b", i, obs_idx[i], obs_key[i], obs_last[i], 10 - i, mdl_keys[10 - i], i == 10);
        end
      end
    end
    n_cmp++; if (rp_post_vld !== 1'b0 || keys_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL dec_end got vld=%b kr=%b busy=%b want 0/1/0", rp_post_vld, keys_ready, busy); end
  endtask

  task automatic test_replay_stall();
    collect_replay(1'b0, 1);
    n_cmp++; if (rp_timeout || obs_key.size() != 11) begin n_err++; $display("FAIL stall_count got %0d keys want 11", obs_key.size()); end
    n_cmp++; if (hold_bad != 0) begin n_err++; $display("FAIL stall_hold got %0d changes during stalls want 0", hold_bad); end
    for (int i = 0; i < obs_key.size() && i < 11; i++) begin
      n_cmp++;
      if (obs_idx[i] != i || obs_key[i] !== mdl_keys[i] || obs_last[i] != (i == 10)) begin
        n_err++; $display("FAIL stall_seq[%0d] got idx %0d key %h want idx %0d key %h", i, obs_idx[i], obs_key[i], i, mdl_keys[i]);
      end
    end
  endtask

  task automatic test_overflow();
    rk_in_valid = 1; rk_in = {$urandom, $urandom, $urandom, $urandom}; step(); rk_in_valid = 0;
    mdl_ovf = 1;
    n_cmp++; if (overflow_err !== mdl_ovf) begin n_err++; $display("FAIL ovf_set got %b want %b", overflow_err, mdl_ovf); end
    repeat (3) step();
    collect_replay(1'b1, 2);
    n_cmp++; if (overflow_err !== mdl_ovf || keys_ready !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got ovf=%b kr=%b want 1/1", overflow_err, keys_ready); end
    n_cmp++; if (rp_timeout || obs_key.size() != 11) begin n_err++; $display("FAIL ovf_replay_count got %0d want 11", obs_key.size()); end
    for (int i = 0; i < obs_key.size() && i < 11; i++) begin
      n_cmp++;
      if (obs_idx[i] != 10 - i || obs_key[i] !== mdl_keys[10 - i]) begin
        n_err++; $display("FAIL ovf_seq[%0d] got idx %0d key %h want idx %0d key %h", i, obs_idx[i], obs_key[i], 10 - i, mdl_keys[10 - i]);
      end
    end
  endtask

  task automatic test_fill_during_replay();
    replay_dir = 0; replay_start = 1; step(); replay_start = 0;
    rk_out_ready = 1;
    repeat (5) step();
    n_cmp++; if (rk_out_valid !== 1'b1 || rk_out_idx !== 4'd5 || rk_out !== mdl_keys[5]) begin n_err++; $display("FAIL mid_replay_key5 got vld=%b idx %0d key %h want 1/5/%h", rk_out_valid, rk_out_idx, rk_out, mdl_keys[5]); end
    rand_src();
    fill_start = 1; rk_in_valid = 1; rk_in = fill_src[0];
    step();
    fill_start = 0; rk_out_ready = 0;
    n_cmp++; if (rk_out_valid !== 1'b0 || keys_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL restart_fill got vld=%b kr=%b busy=%b want 0/0/1", rk_out_valid, keys_ready, busy); end
    for (int i = 1; i < 11; i++) begin
      rk_in = fill_src[i]; step();
    end
    rk_in_valid = 0;
    n_cmp++; if (keys_ready !== 1'b1 || overflow_err !== mdl_ovf) begin n_err++; $display("FAIL refill_done got kr=%b ovf=%b want 1/%b", keys_ready, overflow_err, mdl_ovf); end
    commit_model();
    collect_replay(1'b0, 2);
    n_cmp++; if (rp_timeout || obs_key.size() != 11 || hold_bad != 0) begin n_err++; $display("FAIL refill_replay got %0d keys hold_bad %0d want 11/0", obs_key.size(), hold_bad); end
    for (int i = 0; i < obs_key.size() && i < 11; i++) begin
      n_cmp++;
      if (obs_idx[i] != i || obs_key[i] !== mdl_keys[i]) begin
        n_err++; $display("FAIL refill_seq[%0d] got idx %0d key %h want idx %0d key %h", i, obs_idx[i], obs_key[i], i, mdl_keys[i]);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    rand_src();
    for (int i = 0; i < 6; i++) begin
      fill_start = (i == 0); rk_in_valid = 1; rk_in = fill_src[i]; step();
    end
    reset = 1; fill_start = 1; rk_in_valid = 1; replay_start = 1;
    step();
    idle_inputs();
    mdl_ovf = 0;
    n_cmp++; if (rk_out_valid !== 1'b0 || rk_out !== 128'h0 || rk_out_idx !== 4'd0 || rk_out_last !== 1'b0) begin n_err++; $display("FAIL rst_mid_out got vld=%b key %h idx %0d last %b want 0/0/0/0", rk_out_valid, rk_out, rk_out_idx, rk_out_last); end
    n_cmp++; if (keys_ready !== 1'b0 || busy !== 1'b0 || overflow_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_flags got kr=%b busy=%b ovf=%b want 0/0/0", keys_ready, busy, overflow_err); end
    replay_dir = 1; replay_start = 1; step(); replay_start = 0;
    step();
    n_cmp++; if (rk_out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_replay_ignored got vld=%b busy=%b want 0/0", rk_out_valid, busy); end
  endtask

  task automatic test_random();
    bit dir;
    for (int it = 0; it < 6; it++) begin
      rand_src();
      do_fill(1'b1);
      n_cmp++; if (keys_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rnd_fill[%0d] got kr=%b busy=%b want 1/0", it, keys_ready, busy); end
      commit_model();
      if ($urandom_range(0, 2) == 0) begin
        rk_in_valid = 1; rk_in = {$urandom, $urandom, $urandom, $urandom}; step(); rk_in_valid = 0;
        mdl_ovf = 1;
      end
      dir = 1'($urandom);
      collect_replay(dir, 2);
      n_cmp++; if (rp_timeout || obs_key.size() != 11 || hold_bad != 0 || overflow_err !== mdl_ovf) begin n_err++; $display("FAIL rnd_replay[%0d] got %0d keys hold_bad %0d ovf %b want 11/0/%b", it, obs_key.size(), hold_bad, overflow_err, mdl_ovf); end
      for (int i = 0; i < obs_key.size() && i < 11; i++) begin
        int e;
        e = dir ? 10 - i : i;
        n_cmp++;
        if (obs_idx[i] != e || obs_key[i] !== mdl_keys[e] || obs_last[i] != (i == 10)) begin
          n_err++; $display("FAIL rnd_seq[%0d][%0d] got idx %0d key %h want idx %0d key %h", it, i, obs_idx[i], obs_key[i], e, mdl_keys[e]);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fips_fill();
    test_replay_decrypt();
    test_replay_stall();
    test_overflow();
    test_fill_during_replay();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
